// File: rtl/caesar_decipher.sv
// Bit-serial Caesar decipher: answer = (input1 - input2) mod 2^N, one
// full-subtractor bit per RUN cycle, LSB first, with valid/ready handshakes.
module caesar_decipher #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] answer,
    output logic         borrow_out,
    output logic         out_valid,
    input  logic         out_ready
);

    // Handshake rule (both sides): a transfer happens on a rising edge where
    // valid && ready are both high; valid is never withdrawn by this block
    // until that transfer, and data is held stable while valid is high.

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  res_sr;
    logic [CW-1:0] bit_cnt;
    logic          borrow;

    logic          capture;
    logic          last_bit;
    logic          diff_bit;
    logic          borrow_next;
    logic [N-1:0]  res_next;

    assign capture  = in_valid && in_ready;
    assign last_bit = (bit_cnt == LAST_BIT);

    // One full-subtractor slice operating on the current LSBs.
    assign diff_bit    = a_sr[0] ^ b_sr[0] ^ borrow;
    assign borrow_next = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & borrow) | (b_sr[0] & borrow);
    assign res_next    = {diff_bit, res_sr[N-1:1]};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operands shift right so bit i sits at position 0 on the i-th RUN edge;
    // the result fills from the top so bit 0 lands at the LSB after N shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            bit_cnt    <= '0;
            borrow     <= 1'b0;
            answer     <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        a_sr    <= input1;
                        b_sr    <= input2;
                        res_sr  <= '0;
                        bit_cnt <= '0;
                        borrow  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    borrow <= borrow_next;
                    if (last_bit) begin
                        bit_cnt    <= '0;
                        answer     <= res_next;
                        borrow_out <= borrow_next;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_caesar_decipher.sv
// Self-checking bench for caesar_decipher: table-driven vectors through a
// scoreboard queue, plus hand-written backpressure, ignored-input and reset sequences.
module tb_caesar_decipher;

    localparam int N = 16;

    logic         clk;
    logic         rst;
    logic [N-1:0] input1;
    logic [N-1:0] input2;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] answer;
    logic         borrow_out;
    logic         out_valid;
    logic         out_ready;

    int checks;
    int errors;
    logic [N:0] exp_q[$];

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] ans;
        logic         brw;
        int           hold;
    } vec_t;

    caesar_decipher #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .input1     (input1),
        .input2     (input2),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .answer     (answer),
        .borrow_out (borrow_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Drives one word (optionally pulsing garbage inputs during RUN), checks
    // latency, scoreboard result, DONE stability for 'hold' cycles and release.
    task automatic run_word(input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] ans, input logic brw,
                            input int hold, input bit pulse_in_run);
        int lat;
        logic [N:0] exp;
        logic [N-1:0] snap_ans;
        logic snap_brw;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        input1   = a;
        input2   = b;
        exp_q.push_back({brw, ans});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        input1   = 16'($urandom);
        input2   = 16'($urandom);
        check("in_ready_run", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 3 * N) begin
            in_valid = pulse_in_run && (lat >= 2) && (lat < 6);
            input1   = 16'($urandom);
            input2   = 16'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'(N));
        if (!out_valid) begin
            return;
        end
        if (exp_q.size() == 0) begin
            check("queue_nonempty", 32'd0, 32'd1);
            return;
        end
        exp = exp_q.pop_front();
        check("answer", 32'(answer), 32'(exp[N-1:0]));
        check("borrow_out", 32'(borrow_out), 32'(exp[N]));
        check("in_ready_done", 32'(in_ready), 32'd0);
        snap_ans = answer;
        snap_brw = borrow_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_answer", 32'(answer), 32'(snap_ans));
            check("bp_borrow", 32'(borrow_out), 32'(snap_brw));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        logic [N-1:0] ct;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        input1    = '0;
        input2    = '0;

        vecs.push_back('{16'h0005, 16'h0003, 16'h0002, 1'b0, 0});
        vecs.push_back('{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 0});
        vecs.push_back('{16'h1234, 16'h1234, 16'h0000, 1'b0, 0});
        vecs.push_back('{16'hA5A5, 16'h0000, 16'hA5A5, 1'b0, 0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 0});
        vecs.push_back('{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 0});
        vecs.push_back('{16'h0001, 16'hFFFF, 16'h0002, 1'b1, 0});
        vecs.push_back('{16'h0010, 16'h0001, 16'h000F, 1'b0, 5});
        ct = 16'hBEEF + 16'h4242;
        vecs.push_back('{ct, 16'h4242, 16'hBEEF, 1'b1, 0});
        for (int i = 0; i < 6; i++) begin
            v.a    = 16'($urandom);
            v.b    = 16'($urandom_range(0, 16'hFFFF));
            v.ans  = v.a - v.b;
            v.brw  = (v.a < v.b);
            v.hold = int'($urandom_range(0, 3));
            vecs.push_back(v);
        end

        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_answer", 32'(answer), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        #22;
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_word(vecs[i].a, vecs[i].b, vecs[i].ans, vecs[i].brw, vecs[i].hold, 1'b0);
        end

        // Garbage pulsed on in_valid during RUN must neither alter nor restart.
        run_word(16'h4321, 16'h1111, 16'h3210, 1'b0, 1, 1'b1);
        expect_quiet("no_second_capture", N + 4);

        // Reset while bit 7 is in flight.
        in_valid = 1'b1;
        input1   = 16'h1234;
        input2   = 16'h0101;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_answer", 32'(answer), 32'd0);
        check("midrun_rst_borrow", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_quiet("discarded_word", N + 4);
        run_word(16'h0010, 16'h0001, 16'h000F, 1'b0, 0, 1'b0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/caesar_decipher.md
CAESAR_DECIPHER -- requirements
Module: caesar_decipher

Interface
REQ-001 SHALL have parameter N, default 16: data and key width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port input1, input, N bits: ciphertext word.
REQ-005 SHALL have port input2, input, N bits: key (shift amount).
REQ-006 SHALL have port in_valid, input, 1 bit: input1/input2 valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-008 SHALL have port answer, output, N bits: recovered plaintext.
REQ-009 SHALL have port borrow_out, output, 1 bit: high when input1 < input2 (unsigned wrap occurred).
REQ-010 SHALL have port out_valid, output, 1 bit: answer/borrow_out valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts result.

Function
REQ-012 SHALL compute answer = (input1 - input2) mod 2^N, the inverse of the N-bit modular-add cipher, so that decipher(encipher(p,k),k) = p.
REQ-013 SHALL compute bit-serially, LSB first, one full-subtractor bit per RUN cycle: d = a^b^bin, bout = (~a&b)|(~a&bin)|(b&bin), initial borrow 0.
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 SHALL transition IDLE->RUN on an edge with in_valid && in_ready, capturing input1 and input2 into internal shift registers and clearing the bit counter and borrow.
REQ-016 SHALL stay in RUN for exactly N edges, processing bit index 0..N-1, and transition RUN->DONE on the edge processing bit N-1.
REQ-017 SHALL transition DONE->IDLE on an edge with out_ready high.
REQ-018 SHALL hold DONE indefinitely while out_ready is low.
REQ-019 SHALL drive in_ready = 1 only in IDLE.
REQ-020 SHALL drive out_valid = 1 only in DONE.
REQ-021 SHALL ignore in_valid, input1 and input2 outside IDLE.
REQ-022 SHALL ensure that input changes after the capture edge do not affect the result.
REQ-023 SHALL have latency such that out_valid rises N clock edges after the capture edge; one word takes N+2 cycles minimum including the DONE handshake; no overlap between words.
REQ-024 SHALL hold answer and borrow_out stable throughout DONE.
REQ-025 SHALL set borrow_out to the final borrow after bit N-1.
REQ-026 SHALL leave answer and borrow_out holding the last result in IDLE and RUN; they are meaningful only while out_valid = 1.
REQ-027 SHALL pass through unchanged when input2 = 0: answer = input1, borrow_out = 0.
REQ-028 SHALL give answer = 0 and borrow_out = 0 when input1 = input2.
REQ-029 SHALL size the bit counter as ceil(log2 N) bits, wrapping only via the RUN->DONE transition.

Reset
REQ-030 SHALL, on rst high at any time including mid-RUN or DONE, immediately force state IDLE, in_ready = 1, out_valid = 0, answer = 0, borrow_out = 0, counter = 0, and clear shift registers.
REQ-031 SHALL discard any in-flight word on reset, with no result emitted for it.
REQ-032 SHALL, after rst falls, accept a word on the first edge with in_valid high.

Verification
REQ-033 SHALL cover: input1=0x0005, input2=0x0003 -> answer=0x0002, borrow_out=0, out_valid rises 16 edges after capture.
REQ-034 SHALL cover: input1=0x0000, input2=0x0001 -> answer=0xFFFF, borrow_out=1; and input1=0x1234, input2=0x1234 -> answer=0x0000, borrow_out=0.
REQ-035 SHALL cover round-trip: plaintext 0xBEEF, key 0x4242, ciphertext 0x0131 -> answer=0xBEEF, borrow_out=1.
REQ-036 SHALL cover backpressure: out_ready held low 5 cycles in DONE -> out_valid and answer stable and in_ready=0 throughout; IDLE one edge after out_ready rises.
REQ-037 SHALL cover ignored inputs: in_valid pulsed with different data during RUN -> no effect on result and no second capture.
REQ-038 SHALL cover reset mid-RUN: rst asserted at bit 7 -> outputs at reset values immediately; next word 0x0010-0x0001 -> 0x000F, borrow_out=0.
